// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game sequencer and the note engine.
//   - game_state_e : game_state encoding (IDLE=0, PLAYING=1, PAUSED=2, OVER=3)
//   - NOTE_W       : width of a one-hot piano-key vector
//   - HOLD_W       : width of a note's hold length in beats
//   - sat_add16    : 16-bit saturating add of a hold length onto a score
package game_pkg;

  localparam int NOTE_W = 12;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  // Adds a note length to the score, clamping at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [HOLD_W-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector against a registered previous value.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset (previous value clears to 0)
//   sig_in - level to watch
//   rise   - high for the cycle in which sig_in is 1 and was 0 last cycle
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next previous-value is simply the current level.
  always_comb begin
    prev_d = sig_in;
  end

  // Previous-value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: rhythm-game state machine. Counts song beats, judges each
// note as hit or miss from the keys held while it sounds, keeps score and
// lives, and ends the game on song completion or loss of all lives.
// Parameters: SONG_BEATS (1..255) beats in the song, MAX_LIVES (1..3).
// Ports:
//   game_clock, reset (async active-high)
//   beat_tick   - one-cycle pulse per beat
//   start_btn   - debounced button level (rising edge starts / toggles pause)
//   key_pressed - one bit per key; curr_note - one-hot expected key
//   hold_length - beats of the current note
//   game_frame, score, lives, game_state, hit, miss, win - registered outputs
// Build option: GAME_SEQUENCER_PAUSE_EN enables pause/resume on start edges
// while playing.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SONG_BEATS = 11,
  parameter int MAX_LIVES  = 3
) (
  input  logic              game_clock,
  input  logic              reset,
  input  logic              beat_tick,
  input  logic              start_btn,
  input  logic [NOTE_W-1:0] key_pressed,
  input  logic [NOTE_W-1:0] curr_note,
  input  logic [HOLD_W-1:0] hold_length,
  output logic [7:0]        game_frame,
  output logic [15:0]       score,
  output logic [1:0]        lives,
  output logic [1:0]        game_state,
  output logic              hit,
  output logic              miss,
  output logic              win
);

  localparam logic [7:0] SONG_END   = 8'(SONG_BEATS);
  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);

  game_state_e       state_q, state_d;
  logic [7:0]        frame_q, frame_d;
  logic [15:0]       score_q, score_d;
  logic [1:0]        lives_q, lives_d;
  logic              win_q, win_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] len_q, len_d;
  logic              matched_q, matched_d;
  logic              wrong_q, wrong_d;

  logic              start_rise;
  logic              match_now;
  logic              wrong_now;
  logic              matched_acc;
  logic              wrong_acc;
  logic [HOLD_W-1:0] len_eff;
  logic [HOLD_W-1:0] cnt_inc;
  logic              note_end;

  edge_detect u_start_edge (
    .clk    (game_clock),
    .rst    (reset),
    .sig_in (start_btn),
    .rise   (start_rise)
  );

  assign match_now   = (key_pressed == curr_note) && (curr_note != 12'd0);
  assign wrong_now   = (key_pressed != 12'd0) && (key_pressed != curr_note);
  // Keys seen in the ending cycle still belong to the ending note.
  assign matched_acc = matched_q | match_now;
  assign wrong_acc   = wrong_q | wrong_now;
  // While the counter is 0 the length is being latched this very cycle, so a
  // one-beat note must be judged against the live hold_length.
  assign len_eff     = (cnt_q == 4'd0) ? hold_length : len_q;
  assign cnt_inc     = cnt_q + 4'd1;
  assign note_end    = beat_tick && (cnt_inc == len_eff);

  // Next-state and datapath for the game FSM.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    score_d   = score_q;
    lives_d   = lives_q;
    win_d     = win_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    cnt_d     = cnt_q;
    len_d     = len_q;
    matched_d = matched_q;
    wrong_d   = wrong_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d   = ST_PLAYING;
          frame_d   = 8'd0;
          score_d   = 16'd0;
          lives_d   = LIVES_INIT;
          win_d     = 1'b0;
          cnt_d     = 4'd0;
          len_d     = 4'd0;
          matched_d = 1'b0;
          wrong_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_PLAYING: begin
        if (cnt_q == 4'd0) begin
          len_d = hold_length;
        end else begin
          len_d = len_q;
        end

        if (note_end) begin
          frame_d   = frame_q + 8'd1;
          cnt_d     = 4'd0;
          matched_d = 1'b0;
          wrong_d   = 1'b0;
          if (matched_acc && !wrong_acc) begin
            hit_d   = 1'b1;
            score_d = sat_add16(score_q, len_eff);
          end else begin
            miss_d  = 1'b1;
            lives_d = lives_q - 2'd1;
          end
        end else if (beat_tick) begin
          frame_d   = frame_q + 8'd1;
          cnt_d     = cnt_inc;
          matched_d = matched_acc;
          wrong_d   = wrong_acc;
        end else begin
          matched_d = matched_acc;
          wrong_d   = wrong_acc;
        end

        // Losing the last life outranks finishing the song in the same cycle.
        if (lives_d == 2'd0) begin
          state_d = ST_OVER;
          win_d   = 1'b0;
        end else if (frame_d == SONG_END) begin
          state_d = ST_OVER;
          win_d   = 1'b1;
        end else if (start_rise) begin
`ifdef GAME_SEQUENCER_PAUSE_EN
          state_d = ST_PAUSED;
`else
          state_d = ST_PLAYING;
`endif
        end else begin
          state_d = ST_PLAYING;
        end
      end

      ST_PAUSED: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
        if (start_rise) begin
          state_d = ST_PLAYING;
        end else begin
          state_d = ST_PAUSED;
        end
`else
        // Not reachable in this build; fall back to a safe state.
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge game_clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= 8'd0;
      score_q   <= 16'd0;
      lives_q   <= LIVES_INIT;
      win_q     <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      cnt_q     <= 4'd0;
      len_q     <= 4'd0;
      matched_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      win_q     <= win_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      matched_q <= matched_d;
      wrong_q   <= wrong_d;
    end
  end

  assign game_state = state_q;
  assign game_frame = frame_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign win        = win_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios plus randomized play, checked against
// a note-level reference model of the game rules.
module tb_game_sequencer;

  localparam int SONG_BEATS = 11;
  localparam int MAX_LIVES  = 3;
`ifdef GAME_SEQUENCER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        game_clock = 1'b0;
  logic        reset = 1'b0;
  logic        beat_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] key_pressed = 12'd0;
  logic [11:0] curr_note = 12'd0;
  logic [3:0]  hold_length = 4'd1;
  logic [7:0]  game_frame;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [1:0]  game_state;
  logic        hit;
  logic        miss;
  logic        win;

  int checks = 0;
  int errors = 0;

  // Reference model: game-level view (beats into the current note, whether
  // the right key / any wrong key was seen during that note).
  int m_state, m_frame, m_score, m_lives, m_win, m_hit, m_miss;
  int n_pos, n_len;
  bit n_good, n_bad, m_prev;

  game_sequencer #(.SONG_BEATS(SONG_BEATS), .MAX_LIVES(MAX_LIVES)) dut (
    .game_clock  (game_clock),
    .reset       (reset),
    .beat_tick   (beat_tick),
    .start_btn   (start_btn),
    .key_pressed (key_pressed),
    .curr_note   (curr_note),
    .hold_length (hold_length),
    .game_frame  (game_frame),
    .score       (score),
    .lives       (lives),
    .game_state  (game_state),
    .hit         (hit),
    .miss        (miss),
    .win         (win)
  );

  always #5 game_clock = ~game_clock;

  task automatic model_reset();
    m_state = 0; m_frame = 0; m_score = 0; m_lives = MAX_LIVES; m_win = 0;
    m_hit = 0; m_miss = 0; n_pos = 0; n_len = 0; n_good = 0; n_bad = 0;
    m_prev = 0;
  endtask

  task automatic model_step(input bit beat, input bit start,
                            input logic [11:0] keys, input logic [11:0] note,
                            input logic [3:0] hold);
    bit rise;
    rise = start && !m_prev;
    m_prev = start;
    m_hit = 0;
    m_miss = 0;
    if (m_state == 0 || m_state == 3) begin
      if (rise) begin
        m_state = 1; m_frame = 0; m_score = 0; m_lives = MAX_LIVES; m_win = 0;
        n_pos = 0; n_len = 0; n_good = 0; n_bad = 0;
      end
    end else if (m_state == 1) begin
      if (n_pos == 0) n_len = hold;
      if (note != 0 && keys == note) n_good = 1;
      else if (keys != 0) n_bad = 1;
      if (beat) begin
        m_frame++;
        n_pos++;
        if (n_pos == n_len) begin
          if (n_good && !n_bad) begin
            m_hit = 1;
            m_score = (m_score + n_len > 65535) ? 65535 : m_score + n_len;
          end else begin
            m_miss = 1;
            m_lives--;
          end
          n_pos = 0; n_good = 0; n_bad = 0;
        end
      end
      if (m_lives == 0) begin m_state = 3; m_win = 0; end
      else if (m_frame == SONG_BEATS) begin m_state = 3; m_win = 1; end
      else if (rise && PAUSE_EN) m_state = 2;
    end else begin
      if (rise) m_state = 1;
    end
  endtask

  // One clock: drive inputs, clock, let the model see the same inputs.
  task automatic cycle(input bit beat, input bit start, input logic [11:0] keys,
                       input logic [11:0] note, input logic [3:0] hold);
    beat_tick = beat; start_btn = start; key_pressed = keys;
    curr_note = note; hold_length = hold;
    @(posedge game_clock);
    #1;
    model_step(beat, start, keys, note, hold);
  endtask

  task automatic do_reset();
    beat_tick = 0; start_btn = 0; key_pressed = 0; curr_note = 0; hold_length = 1;
    reset = 1;
    @(posedge game_clock); @(posedge game_clock); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    checks++;
    if (game_state !== 2'd0 || game_frame !== 8'd0 || score !== 16'd0 ||
        lives !== 2'd3 || hit !== 1'b0 || miss !== 1'b0 || win !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d frame=%0d score=%0d lives=%0d hit=%0b miss=%0b win=%0b, need 0/0/0/3/0/0/0",
               game_state, game_frame, score, lives, hit, miss, win);
    end
    do_reset();
  endtask

  task automatic test_start();
    cycle(0, 1, 0, 0, 1);
    checks++;
    if (game_state !== 2'd1 || game_frame !== 8'd0 || lives !== 2'd3 || score !== 16'd0) begin
      errors++;
      $display("FAIL start: state=%0d frame=%0d lives=%0d score=%0d, need 1/0/3/0",
               game_state, game_frame, lives, score);
    end
    // Holding the button high must not act again.
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (game_state !== 2'd1) begin
      errors++;
      $display("FAIL start_level: state=%0d, need 1", game_state);
    end
  endtask

  task automatic test_hit();
    cycle(0, 0, 12'h001, 12'h001, 4'd2);
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_early: hit=%0b after 1st beat, need 0", hit);
    end
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    checks++;
    if (hit !== 1'b1 || miss !== 1'b0 || score !== 16'd2) begin
      errors++;
      $display("FAIL hit: hit=%0b miss=%0b score=%0d, need 1/0/2", hit, miss, score);
    end
    cycle(0, 0, 0, 12'h001, 4'd2);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse: hit=%0b one cycle later, need 0", hit);
    end
  endtask

  task automatic test_miss();
    for (int n = 0; n < 3; n++) begin
      cycle(1, 0, 0, 12'h001, 4'd2);
      cycle(1, 0, 0, 12'h001, 4'd2);
      checks++;
      if (miss !== 1'b1 || lives !== 2'(2 - n)) begin
        errors++;
        $display("FAIL miss%0d: miss=%0b lives=%0d, need 1/%0d", n, miss, lives, 2 - n);
      end
    end
    checks++;
    if (game_state !== 2'd3 || win !== 1'b0 || game_frame !== 8'd8) begin
      errors++;
      $display("FAIL lose: state=%0d win=%0b frame=%0d, need 3/0/8", game_state, win, game_frame);
    end
    // Beats and keys are ignored in OVER.
    cycle(1, 0, 12'h001, 12'h001, 4'd1);
    checks++;
    if (game_frame !== 8'd8 || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL over_idle: frame=%0d hit=%0b miss=%0b, need 8/0/0", game_frame, hit, miss);
    end
  endtask

  task automatic test_wrong();
    cycle(0, 1, 0, 0, 4'd2);
    cycle(0, 0, 12'h001, 12'h001, 4'd2);
    cycle(0, 0, 12'h002, 12'h001, 4'd2);
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || score !== 16'd0 || lives !== 2'd2) begin
      errors++;
      $display("FAIL wrong: miss=%0b hit=%0b score=%0d lives=%0d, need 1/0/0/2", miss, hit, score, lives);
    end
  endtask

  task automatic test_win();
    do_reset();
    cycle(0, 1, 0, 0, 4'd1);
    for (int b = 0; b < SONG_BEATS; b++) cycle(1, 0, 12'h001, 12'h001, 4'd1);
    checks++;
    if (game_state !== 2'd3 || win !== 1'b1 || game_frame !== 8'd11 ||
        score !== 16'd11 || hit !== 1'b1) begin
      errors++;
      $display("FAIL win: state=%0d win=%0b frame=%0d score=%0d hit=%0b, need 3/1/11/11/1",
               game_state, win, game_frame, score, hit);
    end
    cycle(1, 0, 12'h001, 12'h001, 4'd1);
    checks++;
    if (game_frame !== 8'd11 || hit !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap: frame=%0d hit=%0b, need 11/0", game_frame, hit);
    end
    cycle(0, 1, 0, 0, 4'd1);
    checks++;
    if (game_state !== 2'd1 || score !== 16'd0 || game_frame !== 8'd0 ||
        lives !== 2'd3 || win !== 1'b0) begin
      errors++;
      $display("FAIL restart: state=%0d score=%0d frame=%0d lives=%0d win=%0b, need 1/0/0/3/0",
               game_state, score, game_frame, lives, win);
    end
    cycle(0, 0, 0, 0, 4'd1);
  endtask

  task automatic test_pause();
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    cycle(0, 1, 12'h001, 12'h001, 4'd2);
    checks++;
    if (game_state !== (PAUSE_EN ? 2'd2 : 2'd1)) begin
      errors++;
      $display("FAIL pause_enter: state=%0d, need %0d", game_state, PAUSE_EN ? 2 : 1);
    end
    for (int b = 0; b < 5; b++) cycle(1, 0, 12'h002, 12'h001, 4'd2);
    checks++;
    if (game_frame !== (PAUSE_EN ? 8'd1 : 8'(m_frame)) || lives !== 2'(m_lives) ||
        game_state !== 2'(m_state)) begin
      errors++;
      $display("FAIL pause_hold: frame=%0d lives=%0d state=%0d, need %0d/%0d/%0d",
               game_frame, lives, game_state, PAUSE_EN ? 1 : m_frame, m_lives, m_state);
    end
    cycle(0, 1, 0, 12'h001, 4'd2);
    checks++;
    if (game_state !== 2'd1) begin
      errors++;
      $display("FAIL pause_exit: state=%0d, need 1", game_state);
    end
    cycle(0, 0, 0, 12'h001, 4'd2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(0, 1, 0, 0, 4'd2);
    cycle(0, 0, 12'h001, 12'h001, 4'd2);
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    // The next beat would end the note as a hit; reset lands first.
    beat_tick = 1; start_btn = 0; key_pressed = 12'h001;
    #2 reset = 1;
    #1;
    checks++;
    if (game_state !== 2'd0 || game_frame !== 8'd0 || score !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: state=%0d frame=%0d score=%0d, need 0/0/0", game_state, game_frame, score);
    end
    @(posedge game_clock); #1;
    reset = 0;
    model_reset();
    cycle(1, 0, 12'h001, 12'h001, 4'd2);
    checks++;
    if (hit !== 1'b0 || miss !== 1'b0 || game_state !== 2'd0 || game_frame !== 8'd0) begin
      errors++;
      $display("FAIL reset_verdict: hit=%0b miss=%0b state=%0d frame=%0d, need 0/0/0/0",
               hit, miss, game_state, game_frame);
    end
  endtask

  task automatic test_random();
    logic [11:0] note, keys, bit1;
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      note = ($urandom_range(0, 9) == 0) ? 12'd0 : (12'd1 << $urandom_range(0, 11));
      bit1 = 12'd1 << $urandom_range(0, 11);
      r = $urandom_range(0, 9);
      if (r < 6) keys = note;
      else if (r < 8) keys = 12'd0;
      else if (r == 8) keys = 12'($urandom());
      else keys = note | bit1;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, keys, note,
            4'($urandom_range(1, 4)));
      checks++;
      if (game_state !== 2'(m_state) || game_frame !== 8'(m_frame) ||
          score !== 16'(m_score) || lives !== 2'(m_lives) || hit !== 1'(m_hit) ||
          miss !== 1'(m_miss) || win !== 1'(m_win)) begin
        errors++;
        $display("FAIL random@%0d: got st=%0d fr=%0d sc=%0d lv=%0d h=%0b m=%0b w=%0b need %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                 c, game_state, game_frame, score, lives, hit, miss, win,
                 m_state, m_frame, m_score, m_lives, m_hit, m_miss, m_win);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hit();
    test_miss();
    test_wrong();
    test_win();
    test_pause();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
